mem_stage: RTL and testbench

- Memory-access pipeline stage between EX and WB.
- Holds the EX→MEM pipeline register and waits on the data-SRAM read-response handshake for loads.
- Aligns and extends load data, then drives mem_to_wb_bus into WB and a forwarding bus back to ID.
- Requests a pipeline stall while a load response is outstanding.

---
 rtl/mem_stage_pkg.sv | 53 +++++
 rtl/mem_stage_load_align.sv | 28 ++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: bus layouts, load codes, stall polarity,
// FSM states and the load-present decode.
package mem_stage_pkg;

   localparam int EX_TO_MEM_WD = 94;
   localparam int MEM_TO_WB_WD = 84;
   localparam int MEM_TO_ID_WD = 38;
   localparam int STALL_W      = 6;

   localparam int STALL_EX  = 2;
   localparam int STALL_MEM = 3;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LBU = 3'd1;
   localparam logic [2:0] LH  = 3'd2;
   localparam logic [2:0] LHU = 3'd3;
   localparam logic [2:0] LW  = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   typedef struct packed {
      logic [13:0] hilo_bus;
      logic [31:0] pc;
      logic        ram_en;
      logic [3:0]  ram_wen;
      logic [2:0]  load_op;
      logic [1:0]  addr_lo;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } ex_mem_t;

   typedef struct packed {
      logic [13:0] hilo_bus;
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } mem_wb_t;

   function automatic logic is_load(input ex_mem_t r);
      return r.ram_en && (r.ram_wen == 4'd0);
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data aligner: selects byte/halfword by address and extends to 32 bits.
// Ports: load_op, addr_lo, word in; data out (combinational).
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  load_op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
      data     = word;
      unique case (1'b1)
         (load_op == LB):  data = {{24{byte_sel[7]}}, byte_sel};
         (load_op == LBU): data = {24'd0, byte_sel};
         (load_op == LH):  data = {{16{half_sel[15]}}, half_sel};
         (load_op == LHU): data = {16'd0, half_sel};
         default:          data = word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM register, load response tracking FSM,
// load alignment, WB/ID forwarding buses and stall request.
// Ports: clk, rst (async active-low), flush, stall, ex_to_mem_bus,
// data_sram_rdata/rvalid in; mem_to_wb_bus, mem_to_id_bus, stallreq_for_mem out.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [STALL_W-1:0]      stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   input  logic                    data_sram_rvalid,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
   output logic                    stallreq_for_mem
);

   ex_mem_t     r;
   ex_mem_t     r_nxt;
   state_e      state;
   logic [31:0] rbuf;
   logic        mem_stop;
   logic        ex_stop;
   logic        nxt_load;
   logic        cur_load;
   logic [31:0] word_src;
   logic [31:0] aligned;
   logic [31:0] wdata;
   logic        we;
   mem_wb_t     wb;
   logic        unused_stall;

   assign unused_stall = ^{stall[5:4], stall[1:0]};

   assign mem_stop = (stall[STALL_MEM] == STOP);
   assign ex_stop  = (stall[STALL_EX] == STOP);

   always_comb begin
      r_nxt = r;
      if (flush)
         r_nxt = '0;
      else if (ex_stop && !mem_stop)
         r_nxt = '0;
      else if (!mem_stop)
         r_nxt = ex_mem_t'(ex_to_mem_bus);
   end

   assign nxt_load = is_load(r_nxt);
   assign cur_load = is_load(r);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r     <= '0;
         rbuf  <= '0;
         state <= IDLE;
      end else begin
         r <= r_nxt;
         if (flush) begin
            // a request still in flight must have its response swallowed
            state <= (state == WAIT && !data_sram_rvalid) ? DRAIN : IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (nxt_load)
                     state <= WAIT;
               end
               WAIT: begin
                  if (data_sram_rvalid) begin
                     if (mem_stop) begin
                        state <= HOLD;
                        rbuf  <= data_sram_rdata;
                     end else begin
                        state <= nxt_load ? WAIT : IDLE;
                     end
                  end
               end
               HOLD: begin
                  if (!mem_stop)
                     state <= nxt_load ? WAIT : IDLE;
               end
               DRAIN: begin
                  if (data_sram_rvalid)
                     state <= nxt_load ? WAIT : IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      stallreq_for_mem = 1'b0;
      unique case (state)
         WAIT:    stallreq_for_mem = ~data_sram_rvalid;
         DRAIN:   stallreq_for_mem = cur_load;
         default: stallreq_for_mem = 1'b0;
      endcase
   end

   assign word_src = (state == HOLD) ? rbuf : data_sram_rdata;

   mem_stage_load_align u_align (
      .load_op (r.load_op),
      .addr_lo (r.addr_lo),
      .word    (word_src),
      .data    (aligned)
   );

   assign wdata = (state == WAIT || state == HOLD) ? aligned : r.rf_wdata;
   assign we    = r.rf_we & ~stallreq_for_mem;

   always_comb begin
      wb.hilo_bus = r.hilo_bus;
      wb.pc       = r.pc;
      wb.rf_we    = we;
      wb.rf_waddr = r.rf_waddr;
      wb.rf_wdata = wdata;
   end

   assign mem_to_wb_bus = wb;
   assign mem_to_id_bus = {we, r.rf_waddr, wdata};

   // a response with nothing outstanding is a bus protocol error
   a_no_rvalid_in_idle: assert property (
      @(posedge clk) disable iff (!rst)
      !(state == IDLE && data_sram_rvalid));

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// load/ALU/store stream compared against a transaction-level model.
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [5:0]  stall;
   logic [93:0] exbus;
   logic [31:0] rdata;
   logic        rvalid;
   logic [83:0] wb;
   logic [37:0] id;
   logic        stallreq;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [5:0] ST_NONE   = 6'b000000;
   localparam logic [5:0] ST_MEM    = 6'b001111;
   localparam logic [5:0] ST_BUBBLE = 6'b000100;

   mem_stage dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .stall            (stall),
      .ex_to_mem_bus    (exbus),
      .data_sram_rdata  (rdata),
      .data_sram_rvalid (rvalid),
      .mem_to_wb_bus    (wb),
      .mem_to_id_bus    (id),
      .stallreq_for_mem (stallreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [83:0] obs,
                      input logic [83:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [93:0] mk(
      input logic [13:0] hilo, input logic [31:0] pc,
      input logic ram_en, input logic [3:0] wen,
      input logic [2:0] lop, input logic [1:0] a,
      input logic we, input logic [4:0] wa, input logic [31:0] wd);
      return {hilo, pc, ram_en, wen, lop, a, we, wa, wd};
   endfunction

   function automatic logic [83:0] exp_wb(input logic [93:0] op,
                                          input logic [31:0] data);
      return {op[93:48], op[37], op[36:32], data};
   endfunction

   function automatic logic is_ld(input logic [93:0] op);
      return op[47] && (op[46:43] == 4'd0);
   endfunction

   // Reference extension from plain arithmetic on the response word.
   function automatic logic [31:0] ref_ext(input int op, input int a,
                                           input logic [31:0] w);
      int unsigned b;
      int unsigned h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (w >> (16 * (a / 2))) & 32'hFFFF;
      case (op)
         0:       return (b >= 128) ? b - 256 : b;
         1:       return b;
         2:       return (h >= 32768) ? h - 65536 : h;
         3:       return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [93:0] rnd_op();
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0)
         return mk(14'($urandom), $urandom, 1'b0, 4'd0,
                   3'($urandom_range(0, 7)), 2'($urandom), 1'($urandom),
                   5'($urandom), $urandom);
      else if (kind == 1)
         return mk(14'($urandom), $urandom, 1'b1,
                   4'($urandom_range(1, 15)), 3'($urandom), 2'($urandom),
                   1'b0, 5'($urandom), $urandom);
      else
         return mk(14'($urandom), $urandom, 1'b1, 4'd0,
                   3'($urandom_range(0, 4)), 2'($urandom), 1'b1,
                   5'($urandom), $urandom);
   endfunction

   task automatic do_load(input string tag, input logic [2:0] lop,
                          input logic [1:0] a, input logic [31:0] rd,
                          input logic [31:0] exp);
      exbus  = mk(14'h0123, 32'h0000_1000, 1'b1, 4'd0, lop, a, 1'b1,
                  5'd7, 32'h0);
      stall  = ST_NONE;
      rvalid = 1'b0;
      tick();
      exbus  = '0;
      rvalid = 1'b1;
      rdata  = rd;
      #1;
      chk(tag, id, {1'b1, 5'd7, exp});
      chk({tag, "_sr"}, stallreq, 1'b0);
      tick();
      rvalid = 1'b0;
   endtask

   logic [93:0] cur;
   logic [93:0] nxt;
   logic [83:0] ex;
   logic [31:0] rd;
   logic        bub;
   int          lat;
   int          hold;

   initial begin
      rst    = 1'b0;
      flush  = 1'b0;
      stall  = ST_NONE;
      exbus  = '0;
      rdata  = '0;
      rvalid = 1'b0;
      #1;
      chk("rst_wb", wb, '0);
      chk("rst_id", id, '0);
      chk("rst_sr", stallreq, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      tick();

      // ALU result passthrough, then bubble
      exbus = mk(14'h1ABC, 32'hBFC0_0000, 1'b0, 4'd0, 3'd0, 2'd0,
                 1'b1, 5'd8, 32'h5);
      tick();
      #1;
      chk("add_wb", wb, {14'h1ABC, 32'hBFC0_0000, 1'b1, 5'd8, 32'h5});
      chk("add_id", id, {1'b1, 5'd8, 32'h5});
      chk("add_sr", stallreq, 1'b0);
      stall = ST_BUBBLE;
      tick();
      #1;
      chk("bubble_wb", wb, '0);
      chk("bubble_id", id, '0);

      // LW with response one cycle after latch
      stall = ST_NONE;
      exbus = mk(14'h0055, 32'hBFC0_0010, 1'b1, 4'd0, 3'd4, 2'd0,
                 1'b1, 5'd3, 32'h0);
      tick();
      exbus = '0;
      stall = ST_MEM;
      #1;
      chk("lw_wait_sr", stallreq, 1'b1);
      chk("lw_wait_we", id[37], 1'b0);
      tick();
      stall  = ST_NONE;
      rvalid = 1'b1;
      rdata  = 32'h89AB_CDEF;
      #1;
      chk("lw_wb", wb, {14'h0055, 32'hBFC0_0010, 1'b1, 5'd3, 32'h89AB_CDEF});
      chk("lw_sr", stallreq, 1'b0);
      tick();
      rvalid = 1'b0;
      #1;
      chk("lw_idle_wb", wb, '0);

      // alignment and extension
      do_load("lb3", 3'd0, 2'd3, 32'h8012_3456, 32'hFFFF_FF80);
      do_load("lbu3", 3'd1, 2'd3, 32'h8012_3456, 32'h0000_0080);
      do_load("lh2", 3'd2, 2'd2, 32'h8012_3456, 32'hFFFF_8012);
      do_load("lhu0", 3'd3, 2'd0, 32'h8012_3456, 32'h0000_3456);

      // response arrives while MEM is stalled: buffered in HOLD
      exbus = mk(14'h0, 32'h0000_2000, 1'b1, 4'd0, 3'd4, 2'd0, 1'b1,
                 5'd9, 32'h0);
      tick();
      exbus  = '0;
      stall  = ST_MEM;
      rvalid = 1'b1;
      rdata  = 32'hCAFE_F00D;
      #1;
      chk("hold_rv", id, {1'b1, 5'd9, 32'hCAFE_F00D});
      for (int k = 0; k < 2; k++) begin
         tick();
         rvalid = 1'b0;
         rdata  = $urandom;
         #1;
         chk("hold_buf", id, {1'b1, 5'd9, 32'hCAFE_F00D});
         chk("hold_sr", stallreq, 1'b0);
      end
      tick();
      stall = ST_NONE;
      rdata = 32'hDEAD_BEEF;
      #1;
      chk("hold_adv", id, {1'b1, 5'd9, 32'hCAFE_F00D});
      tick();
      #1;
      chk("hold_done", wb, '0);

      // flush mid-wait: stale response must be dropped
      exbus = mk(14'h0, 32'h0000_3000, 1'b1, 4'd0, 3'd4, 2'd0, 1'b1,
                 5'd10, 32'h0);
      tick();
      exbus = '0;
      stall = ST_MEM;
      flush = 1'b1;
      #1;
      chk("fl_wait_sr", stallreq, 1'b1);
      tick();
      flush = 1'b0;
      stall = ST_NONE;
      exbus = mk(14'h0, 32'h0000_3004, 1'b1, 4'd0, 3'd4, 2'd0, 1'b1,
                 5'd11, 32'h0);
      #1;
      chk("fl_drain_sr", stallreq, 1'b0);
      tick();
      exbus  = '0;
      stall  = ST_MEM;
      rvalid = 1'b1;
      rdata  = 32'h1111_1111;
      #1;
      chk("fl_stale_sr", stallreq, 1'b1);
      chk("fl_stale_we", id[37], 1'b0);
      tick();
      stall = ST_NONE;
      rdata = 32'h2222_2222;
      #1;
      chk("fl_new", id, {1'b1, 5'd11, 32'h2222_2222});
      chk("fl_new_sr", stallreq, 1'b0);
      tick();
      rvalid = 1'b0;

      // async reset while waiting
      exbus = mk(14'h3FFF, 32'h0000_4000, 1'b1, 4'd0, 3'd4, 2'd0, 1'b1,
                 5'd12, 32'h0);
      tick();
      exbus = '0;
      stall = ST_MEM;
      #1;
      chk("rw_sr", stallreq, 1'b1);
      rst = 1'b0;
      #1;
      chk("rw_wb", wb, '0);
      chk("rw_id", id, '0);
      chk("rw_sr0", stallreq, 1'b0);
      #2;
      rst   = 1'b1;
      stall = ST_NONE;
      tick();
      #1;
      chk("rw_idle_sr", stallreq, 1'b0);
      chk("rw_idle_wb", wb, '0);

      // randomized stream against the transaction model
      cur    = rnd_op();
      exbus  = cur;
      stall  = ST_NONE;
      rvalid = 1'b0;
      tick();
      for (int i = 0; i < 150; i++) begin
         nxt = rnd_op();
         bub = ($urandom_range(0, 7) == 0);
         if (is_ld(cur)) begin
            lat  = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            rd   = $urandom;
            ex   = exp_wb(cur, ref_ext(int'(cur[42:40]), int'(cur[39:38]),
                                       rd));
            for (int k = 0; k < lat; k++) begin
               exbus  = nxt;
               stall  = ST_MEM;
               rvalid = 1'b0;
               rdata  = $urandom;
               #1;
               chk("rnd_wait_sr", stallreq, 1'b1);
               chk("rnd_wait_we", id[37], 1'b0);
               tick();
            end
            for (int k = 0; k <= hold; k++) begin
               exbus  = nxt;
               rvalid = (k == 0);
               rdata  = (k == 0) ? rd : $urandom;
               stall  = (k < hold) ? ST_MEM : (bub ? ST_BUBBLE : ST_NONE);
               #1;
               chk("rnd_ld_wb", wb, ex);
               chk("rnd_ld_id", id, {46'd0, ex[37:0]});
               chk("rnd_ld_sr", stallreq, 1'b0);
               tick();
            end
            rvalid = 1'b0;
         end else begin
            exbus  = nxt;
            stall  = bub ? ST_BUBBLE : ST_NONE;
            rvalid = 1'b0;
            #1;
            chk("rnd_op_wb", wb, exp_wb(cur, cur[31:0]));
            chk("rnd_op_sr", stallreq, 1'b0);
            tick();
         end
         cur = bub ? '0 : nxt;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
